// File: rtl/result_scoreboard.sv
// In-order result scoreboard: buffers expected records from the reference model and
// checks each actual record from the core against the oldest one, reporting mismatches and timeouts.
module result_scoreboard #(
   parameter int FIELD_W = 32,
   parameter int NFIELDS = 3,
   parameter int DEPTH   = 8,
   parameter int TAG_W   = 7,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       exp_valid,
   output logic                       exp_ready,
   input  logic [NFIELDS*FIELD_W-1:0] exp_data,
   input  logic [TAG_W-1:0]           exp_tag,
   input  logic                       act_valid,
   output logic                       act_ready,
   input  logic [NFIELDS*FIELD_W-1:0] act_data,
   input  logic [NFIELDS-1:0]         cfg_field_en,
   output logic                       err_valid,
   input  logic                       err_ready,
   output logic [1:0]                 err_kind,
   output logic [NFIELDS-1:0]         err_mask,
   output logic [TAG_W-1:0]           err_tag,
   output logic [NFIELDS*FIELD_W-1:0] err_exp,
   output logic [NFIELDS*FIELD_W-1:0] err_act,
   output logic [CNT_W-1:0]           match_cnt,
   output logic [CNT_W-1:0]           mismatch_cnt,
   output logic [$clog2(DEPTH):0]     occupancy
);

   localparam int DATA_W  = NFIELDS * FIELD_W;
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int OCC_W   = PTR_W + 1;
   localparam int WAIT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   typedef enum logic {S_IDLE, S_REPORT} state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   memData_q [DEPTH];
   logic [TAG_W-1:0]    memTag_q  [DEPTH];
   logic [PTR_W-1:0]    wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic [OCC_W-1:0]    count_q, count_d;
   logic [WAIT_W-1:0]   waitCnt_q, waitCnt_d;
   logic [CNT_W-1:0]    matchCnt_q, matchCnt_d, mismatchCnt_q, mismatchCnt_d;
   logic [1:0]          errKind_q, errKind_d;
   logic [NFIELDS-1:0]  errMask_q, errMask_d;
   logic [TAG_W-1:0]    errTag_q, errTag_d;
   logic [DATA_W-1:0]   errExp_q, errExp_d, errAct_q, errAct_d;

   logic                push, pop, notEmpty, timeoutHit, actReady, matchInc, errInc;
   logic [DATA_W-1:0]   headData;
   logic [TAG_W-1:0]    headTag;
   logic [NFIELDS-1:0]  cmpMask;

   assign notEmpty  = (count_q != '0);
   assign exp_ready = (count_q != OCC_W'(DEPTH));
   assign push      = exp_valid && exp_ready;
   assign headData  = memData_q[rdPtr_q];
   assign headTag   = memTag_q[rdPtr_q];
   assign timeoutHit = (TIMEOUT != 0) && (state_q == S_IDLE) && act_valid && !notEmpty
                       && (waitCnt_q == WAIT_W'(TO_LAST));

   always_comb begin
      cmpMask = '0;
      for (int i = 0; i < NFIELDS; i++) begin
         cmpMask[i] = (headData[i*FIELD_W +: FIELD_W] != act_data[i*FIELD_W +: FIELD_W])
                      && cfg_field_en[i];
      end
   end

   // Storage is not reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         memData_q[wrPtr_q] <= exp_data;
         memTag_q[wrPtr_q]  <= exp_tag;
      end
   end

   always_comb begin
      state_d   = state_q;
      actReady  = 1'b0;
      pop       = 1'b0;
      matchInc  = 1'b0;
      errInc    = 1'b0;
      errKind_d = errKind_q;
      errMask_d = errMask_q;
      errTag_d  = errTag_q;
      errExp_d  = errExp_q;
      errAct_d  = errAct_q;
      case (state_q)
         S_IDLE: begin
            if (act_valid && notEmpty) begin
               actReady = 1'b1;
               pop      = 1'b1;
               if (cmpMask == '0) begin
                  matchInc = 1'b1;
               end else begin
                  errInc    = 1'b1;
                  errKind_d = 2'd1;
                  errMask_d = cmpMask;
                  errTag_d  = headTag;
                  errExp_d  = headData;
                  errAct_d  = act_data;
                  state_d   = S_REPORT;
               end
            end else if (timeoutHit) begin
               actReady  = 1'b1;
               errInc    = 1'b1;
               errKind_d = 2'd2;
               errMask_d = '1;
               errTag_d  = '0;
               errExp_d  = '0;
               errAct_d  = act_data;
               state_d   = S_REPORT;
            end
         end
         S_REPORT: begin
            // Release cycle clears the report; the next compare waits for S_IDLE.
            if (err_ready) begin
               state_d   = S_IDLE;
               errKind_d = '0;
               errMask_d = '0;
               errTag_d  = '0;
               errExp_d  = '0;
               errAct_d  = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wrPtr_d = wrPtr_q + PTR_W'(push);
      rdPtr_d = rdPtr_q + PTR_W'(pop);
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + OCC_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - OCC_W'(1);
      end
      waitCnt_d = waitCnt_q;
      if (actReady || !act_valid) begin
         waitCnt_d = '0;
      end else if ((TIMEOUT != 0) && (state_q == S_IDLE) && !notEmpty) begin
         waitCnt_d = waitCnt_q + WAIT_W'(1);
      end
      matchCnt_d = matchCnt_q;
      if (matchInc && (matchCnt_q != {CNT_W{1'b1}})) begin
         matchCnt_d = matchCnt_q + CNT_W'(1);
      end
      mismatchCnt_d = mismatchCnt_q;
      if (errInc && (mismatchCnt_q != {CNT_W{1'b1}})) begin
         mismatchCnt_d = mismatchCnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         wrPtr_q       <= '0;
         rdPtr_q       <= '0;
         count_q       <= '0;
         waitCnt_q     <= '0;
         matchCnt_q    <= '0;
         mismatchCnt_q <= '0;
         errKind_q     <= '0;
         errMask_q     <= '0;
         errTag_q      <= '0;
         errExp_q      <= '0;
         errAct_q      <= '0;
      end else begin
         state_q       <= state_d;
         wrPtr_q       <= wrPtr_d;
         rdPtr_q       <= rdPtr_d;
         count_q       <= count_d;
         waitCnt_q     <= waitCnt_d;
         matchCnt_q    <= matchCnt_d;
         mismatchCnt_q <= mismatchCnt_d;
         errKind_q     <= errKind_d;
         errMask_q     <= errMask_d;
         errTag_q      <= errTag_d;
         errExp_q      <= errExp_d;
         errAct_q      <= errAct_d;
      end
   end

   assign act_ready    = actReady;
   assign err_valid    = (state_q == S_REPORT);
   assign err_kind     = errKind_q;
   assign err_mask     = errMask_q;
   assign err_tag      = errTag_q;
   assign err_exp      = errExp_q;
   assign err_act      = errAct_q;
   assign match_cnt    = matchCnt_q;
   assign mismatch_cnt = mismatchCnt_q;
   assign occupancy    = count_q;

endmodule

// File: tb/tb_result_scoreboard.sv
// Directed bench for result_scoreboard: matches, mismatch report hold, field masking,
// full FIFO, timeout and reset in the middle of a report.
module tb_result_scoreboard;

   localparam int FIELD_W = 32;
   localparam int NFIELDS = 3;
   localparam int DEPTH   = 8;
   localparam int TAG_W   = 7;
   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 16;
   localparam int DW      = NFIELDS * FIELD_W;

   logic               clk = 1'b0;
   logic               rst;
   logic               exp_valid;
   logic               exp_ready;
   logic [DW-1:0]      exp_data;
   logic [TAG_W-1:0]   exp_tag;
   logic               act_valid;
   logic               act_ready;
   logic [DW-1:0]      act_data;
   logic [NFIELDS-1:0] cfg_field_en;
   logic               err_valid;
   logic               err_ready;
   logic [1:0]         err_kind;
   logic [NFIELDS-1:0] err_mask;
   logic [TAG_W-1:0]   err_tag;
   logic [DW-1:0]      err_exp;
   logic [DW-1:0]      err_act;
   logic [CNT_W-1:0]   match_cnt;
   logic [CNT_W-1:0]   mismatch_cnt;
   logic [$clog2(DEPTH):0] occupancy;

   int totalChecks = 0;
   int badChecks   = 0;

   logic [DW-1:0] mExp, mAct, recD, tData, holdRec;

   result_scoreboard #(
      .FIELD_W(FIELD_W), .NFIELDS(NFIELDS), .DEPTH(DEPTH),
      .TAG_W(TAG_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data), .exp_tag(exp_tag),
      .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
      .cfg_field_en(cfg_field_en),
      .err_valid(err_valid), .err_ready(err_ready), .err_kind(err_kind), .err_mask(err_mask),
      .err_tag(err_tag), .err_exp(err_exp), .err_act(err_act),
      .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt), .occupancy(occupancy)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Counts one comparison and reports it if the observed value differs from the expected one.
   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
      totalChecks++;
      if (got !== want) begin
         badChecks++;
         $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pushExp(input logic [DW-1:0] d, input logic [TAG_W-1:0] t);
      exp_data  = d;
      exp_tag   = t;
      exp_valid = 1'b1;
      step();
      exp_valid = 1'b0;
   endtask

   // Presents one actual record and waits (bounded) for it to be consumed.
   task automatic applyStimulus(input logic [DW-1:0] d);
      logic ok;
      ok        = 1'b0;
      act_data  = d;
      act_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (act_ready) begin
            ok = 1'b1;
            break;
         end
      end
      step();
      act_valid = 1'b0;
      checkOutput("act_handshake", 128'(ok), 128'(1));
   endtask

   function automatic logic [DW-1:0] rec(input int k);
      return {3{32'(k)}};
   endfunction

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst = 1'b1; exp_valid = 1'b0; exp_data = '0; exp_tag = '0;
      act_valid = 1'b0; act_data = '0; cfg_field_en = 3'b111; err_ready = 1'b0;
      mExp    = {32'h30, 32'h10, 32'h01};
      mAct    = {32'h30, 32'h11, 32'h01};
      recD    = {3{32'hD}};
      tData   = {3{32'h77}};
      holdRec = {3{32'hAAAA}};

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_err_valid", 128'(err_valid), 128'(0));
      checkOutput("rst_err_kind", 128'(err_kind), 128'(0));
      checkOutput("rst_err_mask", 128'(err_mask), 128'(0));
      checkOutput("rst_err_act", 128'(err_act), 128'(0));
      checkOutput("rst_match", 128'(match_cnt), 128'(0));
      checkOutput("rst_mismatch", 128'(mismatch_cnt), 128'(0));
      checkOutput("rst_act_ready", 128'(act_ready), 128'(0));
      checkOutput("rst_exp_ready", 128'(exp_ready), 128'(1));
      checkOutput("rst_occ", 128'(occupancy), 128'(0));
      step();

      // Three matching records.
      for (int k = 1; k <= 3; k++) pushExp(rec(k), 7'(k));
      @(negedge clk);
      checkOutput("occ_3", 128'(occupancy), 128'(3));
      step();
      for (int k = 1; k <= 3; k++) begin
         applyStimulus(rec(k));
         @(negedge clk);
         checkOutput("match_no_err", 128'(err_valid), 128'(0));
         step();
      end
      @(negedge clk);
      checkOutput("match_cnt_3", 128'(match_cnt), 128'(3));
      checkOutput("occ_drained", 128'(occupancy), 128'(0));
      checkOutput("mismatch_0", 128'(mismatch_cnt), 128'(0));
      step();

      // Field-1 mismatch, report held for four cycles while another actual waits.
      pushExp(mExp, 7'd5);
      pushExp(recD, 7'd6);
      applyStimulus(mAct);
      act_data  = recD;
      act_valid = 1'b1;
      @(negedge clk);
      checkOutput("mm_err_valid", 128'(err_valid), 128'(1));
      checkOutput("mm_kind", 128'(err_kind), 128'(1));
      checkOutput("mm_mask", 128'(err_mask), 128'(3'b010));
      checkOutput("mm_tag", 128'(err_tag), 128'(5));
      checkOutput("mm_exp", 128'(err_exp), 128'(mExp));
      checkOutput("mm_act", 128'(err_act), 128'(mAct));
      checkOutput("mm_cnt", 128'(mismatch_cnt), 128'(1));
      checkOutput("mm_act_ready", 128'(act_ready), 128'(0));
      for (int c = 0; c < 4; c++) begin
         step();
         @(negedge clk);
         checkOutput("hold_valid", 128'(err_valid), 128'(1));
         checkOutput("hold_mask", 128'(err_mask), 128'(3'b010));
         checkOutput("hold_tag", 128'(err_tag), 128'(5));
         checkOutput("hold_act", 128'(err_act), 128'(mAct));
         checkOutput("hold_act_ready", 128'(act_ready), 128'(0));
         checkOutput("hold_occ", 128'(occupancy), 128'(1));
      end
      step();
      err_ready = 1'b1;
      @(negedge clk);
      checkOutput("release_act_ready", 128'(act_ready), 128'(0));
      step();
      err_ready = 1'b0;
      @(negedge clk);
      checkOutput("released_valid", 128'(err_valid), 128'(0));
      checkOutput("released_act_ready", 128'(act_ready), 128'(1));
      step();
      act_valid = 1'b0;
      @(negedge clk);
      checkOutput("after_rel_match", 128'(match_cnt), 128'(4));
      checkOutput("after_rel_occ", 128'(occupancy), 128'(0));
      step();

      // Same mismatch with field 1 disabled counts as a match.
      cfg_field_en = 3'b101;
      pushExp(mExp, 7'd5);
      applyStimulus(mAct);
      @(negedge clk);
      checkOutput("masked_no_err", 128'(err_valid), 128'(0));
      checkOutput("masked_match", 128'(match_cnt), 128'(5));
      checkOutput("masked_mismatch", 128'(mismatch_cnt), 128'(1));
      step();
      cfg_field_en = 3'b111;

      // Fill, simultaneous push+pop, then full.
      for (int k = 0; k < 7; k++) pushExp(rec(k), 7'(k));
      @(negedge clk);
      checkOutput("occ_7", 128'(occupancy), 128'(7));
      step();
      exp_data = rec(7); exp_tag = 7'd7; exp_valid = 1'b1;
      act_data = rec(0); act_valid = 1'b1;
      @(negedge clk);
      checkOutput("pp_act_ready", 128'(act_ready), 128'(1));
      checkOutput("pp_exp_ready", 128'(exp_ready), 128'(1));
      step();
      exp_valid = 1'b0; act_valid = 1'b0;
      @(negedge clk);
      checkOutput("pp_occ", 128'(occupancy), 128'(7));
      step();
      pushExp(rec(8), 7'd8);
      @(negedge clk);
      checkOutput("full_occ", 128'(occupancy), 128'(8));
      checkOutput("full_exp_ready", 128'(exp_ready), 128'(0));
      step();
      exp_data = rec(99); exp_tag = 7'd99; exp_valid = 1'b1;
      step();
      exp_valid = 1'b0;
      @(negedge clk);
      checkOutput("full_hold_occ", 128'(occupancy), 128'(8));
      step();
      for (int k = 1; k <= 8; k++) applyStimulus(rec(k));
      @(negedge clk);
      checkOutput("drain_match", 128'(match_cnt), 128'(14));
      checkOutput("drain_occ", 128'(occupancy), 128'(0));
      checkOutput("drain_no_err", 128'(err_valid), 128'(0));
      step();

      // Timeout on an empty FIFO, with a push landing in the timeout cycle.
      act_data  = tData;
      act_valid = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         checkOutput("to_act_ready", 128'(act_ready), 128'(c == 4));
         step();
         if (c == 3) begin
            exp_data = holdRec; exp_tag = 7'd9; exp_valid = 1'b1;
         end else if (c == 4) begin
            exp_valid = 1'b0; act_valid = 1'b0;
         end
      end
      @(negedge clk);
      checkOutput("to_err_valid", 128'(err_valid), 128'(1));
      checkOutput("to_kind", 128'(err_kind), 128'(2));
      checkOutput("to_mask", 128'(err_mask), 128'(3'b111));
      checkOutput("to_tag", 128'(err_tag), 128'(0));
      checkOutput("to_exp", 128'(err_exp), 128'(0));
      checkOutput("to_act", 128'(err_act), 128'(tData));
      checkOutput("to_mismatch", 128'(mismatch_cnt), 128'(2));
      checkOutput("to_occ", 128'(occupancy), 128'(1));
      step();
      err_ready = 1'b1;
      step();
      err_ready = 1'b0;
      @(negedge clk);
      checkOutput("to_released", 128'(err_valid), 128'(0));
      step();

      // Reset while a report is pending with five entries queued.
      for (int k = 20; k < 25; k++) pushExp(rec(k), 7'(k));
      applyStimulus({3{32'hBBBB}});
      @(negedge clk);
      checkOutput("pre_rst_valid", 128'(err_valid), 128'(1));
      checkOutput("pre_rst_tag", 128'(err_tag), 128'(9));
      checkOutput("pre_rst_mask", 128'(err_mask), 128'(3'b111));
      checkOutput("pre_rst_occ", 128'(occupancy), 128'(5));
      checkOutput("pre_rst_mismatch", 128'(mismatch_cnt), 128'(3));
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("mid_rst_valid", 128'(err_valid), 128'(0));
      checkOutput("mid_rst_occ", 128'(occupancy), 128'(0));
      checkOutput("mid_rst_match", 128'(match_cnt), 128'(0));
      checkOutput("mid_rst_mismatch", 128'(mismatch_cnt), 128'(0));
      checkOutput("mid_rst_kind", 128'(err_kind), 128'(0));
      checkOutput("mid_rst_exp_ready", 128'(exp_ready), 128'(1));

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
